// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the prefetching fetch unit.
package fetch_queue_pkg;

  localparam int unsigned FETCH_STEP = 4;
  localparam logic [31:0] RV_NOP     = 32'h0000_0013;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with clear; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so increment wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (!res_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch unit: pipelined imem requests, PC-tagged instruction queue,
// redirect flush with discard of in-flight responses.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            res_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned CW1 = CW + 1;

  logic [0:0]        state;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard_cnt;
  logic [CW-1:0]     count;
  logic [CW:0]       credits;
  logic [XLEN-1:0]   target;
  logic              grant;
  logic              resp;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [2*XLEN-1:0] fifo_dout;

  assign credits   = {1'b0, count} + {1'b0, outstanding};
  assign target    = redirect_pc & ~XLEN'(3);
  assign imem_addr = fetch_pc;
  assign imem_req  = (state == ST_RUN)
                   & (credits < CW1'(DEPTH))
                   & (outstanding < CW'(MAX_OUTSTANDING))
                   & ~redirect_valid;
  assign grant     = imem_req & imem_gnt;
  // A response with nothing outstanding is stray (e.g. issued before reset).
  assign resp      = imem_rvalid & (outstanding != '0);
  assign push      = resp & (discard_cnt == '0) & ~redirect_valid & (~fifo_full | pop);
  assign pop       = instr_valid & instr_ready & ~redirect_valid;

  assign instr_valid = ~fifo_empty;
  assign instr_data  = instr_valid ? fifo_dout[XLEN-1:0]      : '0;
  assign instr_pc    = instr_valid ? fifo_dout[2*XLEN-1:XLEN] : '0;

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   ({resp_pc, imem_rdata}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state       <= ST_IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state <= ST_RUN;
      if (redirect_valid) begin
        fetch_pc    <= target;
        resp_pc     <= target;
        // outstanding already includes earlier discards, so every remaining
        // in-flight response (minus the one landing now) becomes a discard.
        outstanding <= outstanding - CW'(resp);
        discard_cnt <= outstanding - CW'(resp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(FETCH_STEP);
        if (push)  resp_pc  <= resp_pc + XLEN'(FETCH_STEP);
        case ({grant, resp})
          2'b10:   outstanding <= outstanding + 1'b1;
          2'b01:   outstanding <= outstanding - 1'b1;
          default: outstanding <= outstanding;
        endcase
        if (resp && discard_cnt != '0) discard_cnt <= discard_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with an in-order latency memory model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int lat    = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_queue #(
    .XLEN            (32),
    .RESET_PC        (32'h0),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .res_n          (res_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return RV_NOP | (a << 12);
  endfunction

  // Ends one cycle: records a grant, advances the clock, drives this cycle's
  // response, and returns mid-cycle (negedge) for checks.
  task automatic tick();
    logic rst_now;
    #1;
    rst_now = ~res_n;
    if (imem_req && imem_gnt && !rst_now) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_now) begin
      pend_addr.delete();
      pend_due.delete();
    end
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    tick();
    tick();
    res_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs got valid=%b req=%b data=%h pc=%h, want all 0",
               instr_valid, imem_req, instr_data, instr_pc);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_first_req got req=%b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea;
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      ea = 32'(4 * (c - 1));
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== ea) begin
        fails++;
        $display("FAIL stream_addr c=%0d got req=%b addr=%h, want req=1 addr=%h", c, imem_req, imem_addr, ea);
      end
      if (c < 3) begin
        checks++;
        if (instr_valid !== 1'b0) begin
          fails++;
          $display("FAIL stream_latency c=%0d got valid=%b, want 0", c, instr_valid);
        end
      end else begin
        ea = 32'(4 * (c - 3));
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== ea || instr_data !== mem_word(ea)) begin
          fails++;
          $display("FAIL stream_out c=%0d got valid=%b pc=%h data=%h, want 1 pc=%h data=%h",
                   c, instr_valid, instr_pc, instr_data, ea, mem_word(ea));
        end
      end
    end
  endtask

  task automatic test_stall();
    fetch_entry_t e;
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c >= 6 && c <= 11) begin
        checks++;
        if (imem_req !== 1'b0) begin
          fails++;
          $display("FAIL stall_req c=%0d got req=%b, want 0", c, imem_req);
        end
      end
      if (c >= 6) begin
        e.pc    = (c <= 11) ? 32'h0 : 32'(4 * (c - 11));
        e.instr = mem_word(e.pc);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr_data !== e.instr) begin
          fails++;
          $display("FAIL stall_head c=%0d got valid=%b pc=%h data=%h, want 1 pc=%h data=%h",
                   c, instr_valid, instr_pc, instr_data, e.pc, e.instr);
        end
      end
      if (c == 12) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          fails++;
          $display("FAIL stall_resume c=%0d got req=%b addr=%h, want 1 addr=00000010", c, imem_req, imem_addr);
        end
      end
      instr_ready = (c >= 11);
    end
  endtask

  task automatic test_latency();
    logic [1:10] req_exp = 10'b1101101101;
    logic [1:10] val_exp = 10'b0001101101;
    logic [31:0] ea = 32'h0;
    logic [31:0] ep = 32'h0;
    do_reset();
    lat = 2;
    instr_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (imem_req !== req_exp[c] || (req_exp[c] && imem_addr !== ea)) begin
        fails++;
        $display("FAIL lat_req c=%0d got req=%b addr=%h, want req=%b addr=%h", c, imem_req, imem_addr, req_exp[c], ea);
      end
      if (req_exp[c]) ea = ea + 32'd4;
      checks++;
      if (instr_valid !== val_exp[c] || (val_exp[c] && instr_pc !== ep)) begin
        fails++;
        $display("FAIL lat_out c=%0d got valid=%b pc=%h, want valid=%b pc=%h", c, instr_valid, instr_pc, val_exp[c], ep);
      end
      if (val_exp[c]) ep = ep + 32'd4;
    end
    lat = 1;
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    instr_ready = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      imem_gnt = !(c >= 2 && c <= 4);
      redirect_valid = (c == 7);
      redirect_pc = 32'h103;
      #1;
      case (c)
        7: begin
          checks++;
          if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL redir_pre got req=%b valid=%b pc=%h, want req=0 valid=1 pc=00000000", imem_req, instr_valid, instr_pc);
          end
        end
        8, 11, 12: begin
          checks++;
          if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_flush c=%0d got valid=%b, want 0", c, instr_valid);
          end
        end
        9, 10: begin
          checks++;
          if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== (c == 9 ? 32'h100 : 32'h104)) begin
            fails++;
            $display("FAIL redir_fetch c=%0d got valid=%b req=%b addr=%h, want valid=0 req=1 addr=%h",
                     c, instr_valid, imem_req, imem_addr, (c == 9 ? 32'h100 : 32'h104));
          end
        end
        13: begin
          checks++;
          if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== mem_word(32'h100)) begin
            fails++;
            $display("FAIL redir_target got valid=%b pc=%h data=%h, want 1 pc=00000100 data=%h",
                     instr_valid, instr_pc, instr_data, mem_word(32'h100));
          end
        end
        default: ;
      endcase
    end
    imem_gnt = 1'b1;
    lat = 1;
  endtask

  task automatic test_redirect_collide();
    do_reset();
    lat = 1;
    instr_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      redirect_valid = (c == 5);
      redirect_pc = 32'h200;
      #1;
      if (c == 5) begin
        checks++;
        if (imem_req !== 1'b0 || imem_rvalid !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
          fails++;
          $display("FAIL coll_pre got req=%b rvalid=%b valid=%b pc=%h, want req=0 rvalid=1 valid=1 pc=00000008",
                   imem_req, imem_rvalid, instr_valid, instr_pc);
        end
      end else if (c == 6 || c == 7) begin
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== (c == 6 ? 32'h200 : 32'h204)) begin
          fails++;
          $display("FAIL coll_fetch c=%0d got valid=%b req=%b addr=%h, want valid=0 req=1 addr=%h",
                   c, instr_valid, imem_req, imem_addr, (c == 6 ? 32'h200 : 32'h204));
        end
      end else if (c == 8) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_data !== mem_word(32'h200)) begin
          fails++;
          $display("FAIL coll_target got valid=%b pc=%h data=%h, want 1 pc=00000200 data=%h",
                   instr_valid, instr_pc, instr_data, mem_word(32'h200));
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    checks++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL mid_full got valid=%b req=%b pc=%h, want valid=1 req=0 pc=00000000", instr_valid, imem_req, instr_pc);
    end
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset got valid=%b req=%b data=%h pc=%h, want all 0", instr_valid, imem_req, instr_data, instr_pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0013;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL mid_restart got valid=%b req=%b addr=%h, want valid=0 req=1 addr=00000000", instr_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_stray got valid=%b pc=%h, want valid=0", instr_valid, instr_pc);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(32'h0)) begin
      fails++;
      $display("FAIL mid_first got valid=%b pc=%h data=%h, want 1 pc=00000000 data=%h",
               instr_valid, instr_pc, instr_data, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_latency();
    test_redirect();
    test_redirect_collide();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t, want completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
